// File: rtl/clk_div_bank_pkg.sv
// Shared defaults and divide/phase helpers for the clock-enable generator bank.
package clk_div_bank_pkg;

  localparam int unsigned W_DEF       = 8;
  localparam int unsigned DIV_RST_DEF = 10;

  // A programmed divide of 0 behaves exactly like a divide of 1.
  function automatic int unsigned eff_div(input int unsigned div);
    return (div == 0) ? 1 : div;
  endfunction

  // Start phase must land inside the period, otherwise the channel starts at 0.
  function automatic int unsigned clamp_phase(input int unsigned ph, input int unsigned div);
    return (ph < eff_div(div)) ? ph : 0;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow settings, period counter, and registered
// enable/tick outputs. Shadow settings move to active only at a period boundary.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_i,
  input  logic         wr_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] ph_i,
  output logic         clk_en_o,
  output logic         tick_o,
  output logic         pend_o
);

  logic [W-1:0] div_a_q, hi_a_q, ph_a_q, div_s_q, hi_s_q, ph_s_q, count_q;
  logic [W-1:0] div_a_d, hi_a_d, ph_a_d, div_s_d, hi_s_d, ph_s_d, count_d;
  logic         pend_q, clk_en_q, tick_q;
  logic         pend_d, clk_en_d, tick_d;
  logic         wrap, apply;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    div_a_d  = div_a_q;
    hi_a_d   = hi_a_q;
    ph_a_d   = ph_a_q;
    div_s_d  = div_s_q;
    hi_s_d   = hi_s_q;
    ph_s_d   = ph_s_q;
    count_d  = count_q;
    pend_d   = pend_q;
    clk_en_d = 1'b0;
    tick_d   = 1'b0;

    wrap  = (32'(count_q) == eff_div(32'(div_a_q)) - 32'd1);
    apply = !en_i || wrap;

    if (apply) begin
      div_a_d = div_s_q;
      hi_a_d  = hi_s_q;
      ph_a_d  = ph_s_q;
      pend_d  = 1'b0;
    end

    // A write on an apply edge lands after the old shadow has been consumed.
    if (wr_i) begin
      div_s_d = div_i;
      hi_s_d  = hi_i;
      ph_s_d  = ph_i;
      pend_d  = 1'b1;
    end

    if (!en_i) begin
      count_d = W'(clamp_phase(32'(ph_s_q), 32'(div_s_q)));
    end else begin
      clk_en_d = (count_q < hi_a_q);
      tick_d   = (count_q == '0);
      count_d  = wrap ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked branch and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_a_q  <= W'(DIV_RST);
      hi_a_q   <= W'(DIV_RST / 2);
      ph_a_q   <= '0;
      div_s_q  <= W'(DIV_RST);
      hi_s_q   <= W'(DIV_RST / 2);
      ph_s_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      clk_en_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_a_q  <= div_a_d;
      hi_a_q   <= hi_a_d;
      ph_a_q   <= ph_a_d;
      div_s_q  <= div_s_d;
      hi_s_q   <= hi_s_d;
      ph_s_q   <= ph_s_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign tick_o   = tick_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock-enable channels sharing one config write port.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF,
  parameter int unsigned CH_W    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] ch_en,
  input  logic            cfg_wr,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_div,
  input  logic [W-1:0]    cfg_hi,
  input  logic [W-1:0]    cfg_phase,
  output logic [N_CH-1:0] clk_en,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] pend
);

  logic [N_CH-1:0] wr_sel;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel indices match no channel, so those writes vanish.
    assign wr_sel[i] = cfg_wr && (32'(cfg_ch) == i);

    clk_div_chan #(
      .W       (W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .en_i     (ch_en[i]),
      .wr_i     (wr_sel[i]),
      .div_i    (cfg_div),
      .hi_i     (cfg_hi),
      .ph_i     (cfg_phase),
      .clk_en_o (clk_en[i]),
      .tick_o   (tick[i]),
      .pend_o   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a reset/default-divide vector table plus
// hand-written sequences for reconfiguration, phase, bypass and reset corners.
module tb_clk_div_bank;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int CH_W = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N_CH-1:0] ch_en;
  logic            cfg_wr;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_div, cfg_hi, cfg_phase;
  logic [N_CH-1:0] clk_en, tick, pend;

  int n_vec = 0;
  int n_err = 0;

  clk_div_bank #(
    .N_CH    (N_CH),
    .W       (W),
    .DIV_RST (10),
    .CH_W    (CH_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ch_en     (ch_en),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_hi    (cfg_hi),
    .cfg_phase (cfg_phase),
    .clk_en    (clk_en),
    .tick      (tick),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  // Expected {pend, tick, clk_en} with only channel ch contributing.
  function automatic logic [11:0] ex(input int ch, input bit p, input bit t, input bit e);
    logic [11:0] v;
    v         = '0;
    v[8 + ch] = p;
    v[4 + ch] = t;
    v[ch]     = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {pend, tick, clk_en};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pend=%b tick=%b clk_en=%b, want pend=%b tick=%b clk_en=%b",
               name, act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Drive inputs, take one rising edge, and settle 1 time unit past it.
  task automatic step(input logic [3:0] en, input logic wr, input logic [2:0] ch,
                      input logic [7:0] d, input logic [7:0] h, input logic [7:0] p);
    ch_en     = en;
    cfg_wr    = wr;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_hi    = h;
    cfg_phase = p;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic idle(input logic [3:0] en);
    step(en, 1'b0, 3'd0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(4'b0000);
    idle(4'b0000);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        rstn;
    logic [3:0]  en;
    logic        wr;
    logic [2:0]  ch;
    logic [7:0]  div;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] div;
    logic [7:0] hi;
    int         period;
    bit         level;
  } byp_t;

  vec_t tab[16];
  byp_t byp[4];

  initial begin
    // Reset, then channel 0 alone at the default divide of 10, high 5.
    tab[0]  = '{1'b0, 4'b0000, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[1]  = '{1'b0, 4'b1111, 1'b1, 3'd0, 8'd3, 12'h000};
    tab[2]  = '{1'b1, 4'b0000, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[3]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h011};
    tab[4]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h001};
    tab[5]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h001};
    tab[6]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h001};
    tab[7]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h001};
    tab[8]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[9]  = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[10] = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[11] = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[12] = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h000};
    tab[13] = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h011};
    tab[14] = '{1'b1, 4'b0001, 1'b0, 3'd0, 8'd0, 12'h001};
    tab[15] = '{1'b1, 4'b0000, 1'b0, 3'd0, 8'd0, 12'h000};

    byp[0] = '{8'd0,  8'd5,   1,  1'b1};
    byp[1] = '{8'd1,  8'd5,   1,  1'b1};
    byp[2] = '{8'd10, 8'd0,   10, 1'b0};
    byp[3] = '{8'd10, 8'd200, 10, 1'b1};

    rstn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rstn = tab[i].rstn;
      step(tab[i].en, tab[i].wr, tab[i].ch, tab[i].div, 8'd5, 8'd0);
      check($sformatf("default_vec%0d", i), tab[i].exp);
    end

    // Reprogram running ch1 to div 4 / hi 1; new period starts after the div-10 wrap.
    do_reset();
    for (int j = 0; j < 26; j++) begin
      bit e, t, p;
      step(4'b0010, j == 3, 3'd1, 8'd4, 8'd1, 8'd0);
      p = (j >= 3) && (j <= 8);
      if (j < 10) begin
        e = (j < 5);
        t = (j == 0);
      end else begin
        e = ((j - 10) % 4 == 0);
        t = e;
      end
      check($sformatf("reprog_j%0d", j), ex(1, p, t, e));
    end

    // Two channels, div 8 hi 4, phases 0 and 4, enabled together: complementary.
    do_reset();
    step(4'b0000, 1'b1, 3'd0, 8'd8, 8'd4, 8'd0);
    check("wr_latency", ex(0, 1, 0, 0));
    step(4'b0000, 1'b1, 3'd1, 8'd8, 8'd4, 8'd4);
    check("wr_ch1_pend", ex(1, 1, 0, 0));
    idle(4'b0000);
    check("disabled_apply", 12'h000);
    for (int j = 0; j < 16; j++) begin
      idle(4'b0011);
      check($sformatf("phase_j%0d", j),
            ex(0, 0, (j % 8) == 0, (j % 8) < 4) | ex(1, 0, (j % 8) == 4, ((j + 4) % 8) < 4));
    end

    // Bypass and duty extremes on ch2.
    for (int c = 0; c < 4; c++) begin
      do_reset();
      step(4'b0000, 1'b1, 3'd2, byp[c].div, byp[c].hi, 8'd0);
      idle(4'b0000);
      for (int j = 0; j < 12; j++) begin
        idle(4'b0100);
        check($sformatf("byp%0d_j%0d", c, j), ex(2, 0, (j % byp[c].period) == 0, byp[c].level));
      end
    end

    // Write on ch2's wrap edge, then an out-of-range write to channel 5.
    do_reset();
    for (int j = 0; j < 31; j++) begin
      bit e, t, p, w;
      logic [2:0] ch;
      logic [7:0] d, h;
      w  = (j == 2) || (j == 9) || (j == 20);
      ch = (j == 20) ? 3'd5 : 3'd2;
      d  = (j == 2) ? 8'd4 : (j == 9) ? 8'd6 : 8'd3;
      h  = (j == 2) ? 8'd2 : (j == 9) ? 8'd3 : 8'd1;
      step(4'b0100, w, ch, d, h, 8'd0);
      p = (j >= 2) && (j <= 12);
      if (j < 10) begin
        e = (j < 5);
        t = (j == 0);
      end else if (j < 14) begin
        e = (j - 10) < 2;
        t = (j == 10);
      end else begin
        e = ((j - 14) % 6) < 3;
        t = ((j - 14) % 6) == 0;
      end
      check($sformatf("wrap_wr_j%0d", j), ex(2, p, t, e));
    end

    // Reset mid-period with a pending config on ch0.
    do_reset();
    for (int j = 0; j < 6; j++) begin
      step(4'b0001, j == 2, 3'd0, 8'd4, 8'd2, 8'd0);
      check($sformatf("pre_rst_j%0d", j), ex(0, j >= 2, j == 0, j < 5));
    end
    rstn = 1'b0;
    step(4'b0001, 1'b1, 3'd0, 8'd3, 8'd1, 8'd0);
    check("reset_mid", 12'h000);
    rstn = 1'b1;
    for (int j = 0; j < 12; j++) begin
      idle(4'b0001);
      check($sformatf("post_rst_j%0d", j), ex(0, 0, (j % 10) == 0, (j % 10) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
